// File: rtl/bht_update_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : bht_update_buffer
//  Description : Decoupling FIFO between the execute-stage branch unit and the
//                branch history table (BHT) update port. Resolved conditional
//                branch outcomes {pc, taken} are captured every cycle without
//                back-pressuring execute and drained one per cycle to the BHT.
//                The updates are prediction hints only, so:
//                  - on overflow the incoming update is dropped and counted
//                    (the counter saturates),
//                  - in debug mode incoming resolutions are ignored,
//                  - a branch-prediction flush discards everything buffered.
//
//  Ports       :
//    clk_i         in   1                 clock, rising edge
//    rst_i         in   1                 synchronous active-high reset
//    flush_bp_i    in   1                 discard all buffered entries
//    debug_mode_i  in   1                 ignore incoming resolutions
//    res_valid_i   in   1                 resolved branch this cycle
//    res_pc_i      in   VLEN              pc of the resolved branch
//    res_taken_i   in   1                 resolved direction
//    bht_valid_o   out  1                 head entry presented to BHT
//    bht_pc_o      out  VLEN              head entry pc
//    bht_taken_o   out  1                 head entry direction
//    bht_ready_i   in   1                 BHT accepts head entry
//    count_o       out  $clog2(DEPTH+1)   current occupancy
//    drop_cnt_o    out  DROP_CNT_W        saturating overflow-drop count
//
//  Revision    : 1.0  initial release
// ============================================================================
module bht_update_buffer #(
    parameter int VLEN       = 64,
    parameter int DEPTH      = 4,
    parameter int DROP_CNT_W = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_bp_i,
    input  logic                         debug_mode_i,
    input  logic                         res_valid_i,
    input  logic [VLEN-1:0]              res_pc_i,
    input  logic                         res_taken_i,
    output logic                         bht_valid_o,
    output logic [VLEN-1:0]              bht_pc_o,
    output logic                         bht_taken_o,
    input  logic                         bht_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [DROP_CNT_W-1:0]        drop_cnt_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    // ------------------------------------------------------------------------
    // Storage. Payload is deliberately not reset: occupancy alone decides
    // whether an entry is meaningful.
    // ------------------------------------------------------------------------
    logic [VLEN-1:0]     r_pc_mem    [DEPTH];
    logic                r_taken_mem [DEPTH];

    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_acc;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_drop_sat;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(DEPTH));

    // An incoming resolution is only a candidate when not in debug mode and
    // not being flushed in the same cycle.
    assign w_acc   = res_valid_i & ~debug_mode_i & ~flush_bp_i;

    // Flush masks the head so the BHT never consumes an entry that is being
    // discarded in the same cycle.
    assign bht_valid_o = ~w_empty & ~flush_bp_i;
    assign w_pop       = bht_valid_o & bht_ready_i;

    // A full buffer still accepts when the head leaves in the same cycle,
    // since the freed slot is the one being written.
    assign w_push      = w_acc & (~w_full | w_pop);
    assign w_drop      = w_acc & w_full & ~w_pop;
    assign w_drop_sat  = &r_drop_cnt;

    // First-word fall-through from registered storage; no input bypass.
    assign bht_pc_o    = r_pc_mem[r_rd_ptr];
    assign bht_taken_o = r_taken_mem[r_rd_ptr];

    assign count_o     = r_count;
    assign drop_cnt_o  = r_drop_cnt;

    // ------------------------------------------------------------------------
    // Payload write
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= res_pc_i;
            r_taken_mem[r_wr_ptr] <= res_taken_i;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers and occupancy. Pointers wrap naturally (DEPTH is a power of
    // two). Flush restarts both pointers at zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_bp_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Saturating drop counter; survives flush, cleared only by reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drop_cnt <= '0;
        end else if (w_drop && !w_drop_sat) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: doc/bht_update_buffer.md
Name: bht_update_buffer

Overview:
- Decoupling FIFO between the execute-stage branch unit and the branch history table update port.
- Captures resolved conditional-branch outcomes (pc, taken) every cycle without ever back-pressuring execute.
- Drains one update per cycle to the BHT when the BHT signals ready.
- Updates are prediction hints: on overflow they are dropped and counted; in debug mode they are filtered; on a branch-prediction flush they are discarded.

Parameters:
- VLEN, 64, virtual address width of the branch pc.
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- flush_bp_i  in  1  branch-prediction flush; discards all buffered entries.
- debug_mode_i  in  1  core in debug mode; incoming resolutions are ignored.
- res_valid_i  in  1  resolved conditional branch this cycle (no ready; always sampled).
- res_pc_i  in  VLEN  pc of the resolved branch.
- res_taken_i  in  1  resolved direction.
- bht_valid_o  out  1  head entry presented to BHT update port.
- bht_pc_o  out  VLEN  head entry pc.
- bht_taken_o  out  1  head entry direction.
- bht_ready_i  in  1  BHT accepts the head entry this cycle.
- count_o  out  $clog2(DEPTH+1)  current occupancy.
- drop_cnt_o  out  DROP_CNT_W  number of updates dropped on overflow since reset; saturating.

Behaviour:
- Storage: DEPTH entries {pc, taken}, read pointer, write pointer ($clog2(DEPTH) bits, natural wrap), occupancy counter 0..DEPTH.
- Reset (rst_i=1 at clock edge): pointers=0, count=0, drop_cnt=0. Entry payload is not reset. After reset: bht_valid_o=0, count_o=0, drop_cnt_o=0; bht_pc_o/bht_taken_o don't-care while bht_valid_o=0. Reset overrides flush and all other inputs.
- Definitions:
  - empty = (count==0); full = (count==DEPTH).
  - acc = res_valid_i & ~debug_mode_i & ~flush_bp_i.
  - pop = bht_valid_o & bht_ready_i.
- Output: bht_valid_o = ~empty & ~flush_bp_i; bht_pc_o/bht_taken_o = entry[rd_ptr]. This is first-word fall-through from registered storage.
- Latency: an entry accepted in cycle N is visible on bht_valid_o in N+1 at the earliest. There is no same-cycle input-to-output bypass.
- Push when acc & (~full | pop): write entry[wr_ptr], wr_ptr+1.
- Pop when pop: rd_ptr+1.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous pop: new entry accepted, count stays DEPTH, no drop.
- Empty: bht_ready_i has no effect; no underflow.
- Drop: acc & full & ~pop means the entry is discarded and drop_cnt increments, holding at 2^DROP_CNT_W-1.
- Debug: res_valid_i while debug_mode_i=1 is neither stored nor counted as a drop. Buffered entries continue draining in debug mode.
- Flush (flush_bp_i=1, rst_i=0):
  - bht_valid_o forced 0 that cycle, so no pop.
  - Incoming resolution ignored, not counted.
  - Next cycle: pointers=0, count=0.
  - drop_cnt unchanged (cleared only by reset).
- Ordering: strict FIFO. Two updates to the same pc are delivered separately, in arrival order, with no merging.
- One push and one pop maximum per cycle.

Test Plan:
- Reset then idle → bht_valid_o=0, count_o=0, drop_cnt_o=0. Single res_valid_i pc=0x8000_0010 taken=1 in cycle N with bht_ready_i=0 → cycle N+1: bht_valid_o=1, bht_pc_o=0x8000_0010, bht_taken_o=1, count_o=1.
- DEPTH=4, bht_ready_i=0, six consecutive resolutions pc=0x100,0x104..0x114 → count_o=4, drop_cnt_o=2. Then bht_ready_i=1 → drains 0x100,0x104,0x108,0x10C in order, then bht_valid_o=0.
- Full FIFO, bht_ready_i=1 and res_valid_i pc=0x200 same cycle → count_o stays 4, drop_cnt_o unchanged, 0x200 emerges fourth after the three remaining older entries.
- debug_mode_i=1 with three resolutions → count_o and drop_cnt_o unchanged. Pre-loaded entry still drains when bht_ready_i=1.
- Three entries buffered, drop_cnt_o=5, flush_bp_i=1 with res_valid_i=1 → bht_valid_o=0 that cycle. Next cycle count_o=0, drop_cnt_o=5. Following push appears at pc written, proving pointers restart cleanly.
- Wrap/saturation: DROP_CNT_W=2, 10 overflow drops → drop_cnt_o=3. Run 3×DEPTH push/pop cycles through pointer wrap → output order matches input order exactly. Assert rst_i mid-stream → next cycle all outputs at reset values.
